alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Multi-cycle ALU datapath that consumes the 4-bit ALUCtrl code produced by ALU control decode and executes it.
//  Sits in EX stage between register-read operands and writeback; valid/ready on both sides.
//  Single-cycle ops finish in one state transition; MULA (multiply-accumulate) iterates through a shift-add multiplier.
// PARAMETERS
//  W      32  operand/result width
//  SHW     5  shift-amount width, $clog2(W)
// PORTS
//  Clk       in   1    rising-edge clock
//  Reset     in   1    synchronous, active-high reset
//  InValid   in   1    operation presented
//  InReady   out  1    unit can accept (state IDLE)
//  ALUCtrl   in   4    operation code
//  A         in   W    operand A (rs)
//  B         in   W    operand B (rt / imm)
//  Shamt     in   SHW  shift amount for SLL/SRL/SRA (shifts B)
//  OutValid  out  1    result held valid
//  OutReady  in   1    consumer takes result
//  Result    out  W    result
//  Zero      out  1    Result == 0
//  Overflow  out  1    signed overflow, ADD/SUB only
//  Illegal   out  1    ALUCtrl was 1110 or 1111
// BEHAVIOUR
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0101 MULA, 0110 SUB, 0111 SLT,
//   1000 ADDU, 1001 SUBU, 1010 XOR, 1011 SLTU, 1100 NOR, 1101 SRA; 1110/1111 illegal -> Result 0, Illegal 1.
//  Reset: state IDLE; InReady 1 in the cycle after; OutValid, Result, Zero, Overflow, Illegal, Acc all 0.
//  FSM IDLE -> (InValid, non-MULA) DONE; IDLE -> (InValid, MULA) MUL; MUL -> (iteration done) DONE;
//   DONE -> (OutReady) IDLE. InReady = (state==IDLE); no accept in the DONE/OutReady cycle.
//  Latency: non-MULA result OutValid 1 cycle after accept; MULA OutValid W+1 cycles after accept.
//  Operands/code registered at accept; input changes afterwards have no effect.
//  Outputs stable while OutValid && !OutReady.
//  ADD/SUB: W-bit wrap; Overflow = signed overflow. ADDU/SUBU: same sum, Overflow 0. Other ops: Overflow 0.
//  SLT signed, SLTU unsigned compare -> Result {W-1 zeros, lt}.
//  SRA sign-fills from B[W-1]; Shamt 0 passes B unchanged.
//  MULA: internal W-bit Acc; Acc <= Acc + low W bits of A*B (mod 2^W); Result = new Acc.
//   Shift-add, one multiplier bit per cycle. Acc persists across ops; only Reset clears it.
//  Reset mid-MULA aborts: no OutValid, Acc cleared to 0.
//  Reset while DONE drops OutValid without handshake.
// CONFIGURATION
//  ALU_MULT_EARLY_EXIT_EN defined: MUL exits once remaining multiplier bits are all zero (min 1 MUL cycle).
//   MULA latency = max(1, index of highest set bit of B + 1) + 1.
//  Undefined: fixed W MUL cycles regardless of operand.
//  Result identical in both builds.
// STRUCTURE
//  Package alu_ctrl_pkg: localparam codes ALU_AND..ALU_SRA (4-bit), state enum IDLE/MUL/DONE.
//  Shared with ALU control decode so both ends use one code table.
//  Sub-module alu_iter_mult: start/busy/done, shift-add multiplier, W-bit product low half; hosts the early-exit logic.
// TESTING
//  1 ADD 0x7FFFFFFF+1 -> Result 0x80000000, Overflow 1, OutValid 1 cycle after accept; ADDU same -> Overflow 0.
//  2 SUB 5-5 -> Result 0, Zero 1; SLT A=-1,B=1 -> 1; SLTU A=0xFFFFFFFF,B=1 -> 0.
//  3 SRA B=0x80000000 Shamt 4 -> 0xF8000000; SRL -> 0x08000000; SLL B=1 Shamt 31 -> 0x80000000.
//  4 MULA 3*4 then MULA 5*6 from reset -> Results 12 then 42.
//   Latency 33 cycles; with ALU_MULT_EARLY_EXIT_EN, 4 and 4 cycles (B=4, B=6).
//  5 Backpressure: hold OutReady 0 for 5 cycles -> Result stable, InReady 0, new InValid ignored.
//  6 Assert Reset during MUL cycle 10 -> no OutValid; next MULA 2*3 -> Result 6 (Acc cleared). ALUCtrl 1111 -> Illegal 1, Result 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control code table and EX-unit FSM state encodings.
// Imported by both ALU control decode and alu_exec_unit so the two sides use one code table.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_MULA = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef logic [1:0] alu_state_t;
    localparam alu_state_t IDLE = 2'd0;
    localparam alu_state_t MUL  = 2'd1;
    localparam alu_state_t DONE = 2'd2;

    // Codes 1110 and 1111 are unassigned.
    function automatic logic is_illegal(input logic [3:0] code);
        return code[3:1] == 3'b111;
    endfunction

endpackage

// File: rtl/alu_iter_mult.sv
// Iterative shift-add multiplier returning the low W bits of a*b, one multiplier bit per cycle.
// Optional early exit when remaining multiplier bits are zero: define ALU_MULT_EARLY_EXIT_EN.
module alu_iter_mult #(
    parameter int unsigned W   = 32,
    parameter int unsigned SHW = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    logic [W-1:0]   mcand_q;
    logic [W-1:0]   mplier_q;
    logic [W-1:0]   prod_q;
    logic [SHW-1:0] cnt_q;
    logic           busy_q;
    logic           last_bit;

`ifdef ALU_MULT_EARLY_EXIT_EN
    // Stop as soon as no set multiplier bits remain above the one being consumed now.
    assign last_bit = (mplier_q[W-1:1] == '0) || (cnt_q == SHW'(W - 1));
`else
    assign last_bit = (cnt_q == SHW'(W - 1));
`endif

    assign busy    = busy_q;
    assign done    = busy_q && last_bit;
    // Includes the current bit, so it is the full product in the done cycle.
    assign product = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            prod_q   <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (last_bit) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU executing ALUCtrl codes with valid/ready handshakes; MULA accumulates via alu_iter_mult.
// Define ALU_MULT_EARLY_EXIT_EN to let the multiplier exit once remaining multiplier bits are zero.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SHW = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    output logic           InReady,
    input  logic [3:0]     ALUCtrl,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [SHW-1:0] Shamt,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [W-1:0]   Result,
    output logic           Zero,
    output logic           Overflow,
    output logic           Illegal
);

    alu_state_t     state_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   result_q;
    logic           zero_q;
    logic           ovf_q;
    logic           ill_q;

    logic           accept;
    logic           is_mula;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic           mult_busy;
    logic           mult_done;
    logic [W-1:0]   mult_product;
    logic [W-1:0]   acc_next;

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign Illegal  = ill_q;

    assign accept   = InValid && InReady;
    assign is_mula  = (ALUCtrl == ALU_MULA);
    assign sum      = A + B;
    assign diff     = A - B;
    assign acc_next = acc_q + mult_product;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl)
            ALU_AND:  alu_res = A & B;
            ALU_OR:   alu_res = A | B;
            ALU_XOR:  alu_res = A ^ B;
            ALU_NOR:  alu_res = ~(A | B);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
            end
            ALU_ADDU: alu_res = sum;
            ALU_SUBU: alu_res = diff;
            ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: alu_res = {{(W-1){1'b0}}, (A < B)};
            ALU_SLL:  alu_res = B << Shamt;
            ALU_SRL:  alu_res = B >> Shamt;
            ALU_SRA:  alu_res = $signed(B) >>> Shamt;
            default:  alu_res = '0;
        endcase
    end

    alu_iter_mult #(
        .W   (W),
        .SHW (SHW)
    ) u_mult (
        .clk     (Clk),
        .reset   (Reset),
        .start   (accept && is_mula),
        .a       (A),
        .b       (B),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mula) begin
                            state_q <= MUL;
                        end else begin
                            state_q  <= DONE;
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                            ill_q    <= is_illegal(ALUCtrl);
                        end
                    end
                end
                MUL: begin
                    if (mult_busy && mult_done) begin
                        state_q  <= DONE;
                        acc_q    <= acc_next;
                        result_q <= acc_next;
                        zero_q   <= (acc_next == '0);
                        ovf_q    <= 1'b0;
                        ill_q    <= 1'b0;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors pushed as expectations, monitor checks outputs.
// Expected MULA latency follows ALU_MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        ill;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        i;
        int          lat;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    logic prev_ov = 1'b0;
    logic [31:0] held;

    alu_exec_unit #(
        .W   (32),
        .SHW (5)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .ALUCtrl  (ctrl),
        .A        (op_a),
        .B        (op_b),
        .Shamt    (shamt),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Result   (result),
        .Zero     (zero),
        .Overflow (ovf),
        .Illegal  (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int mula_lat(input logic [31:0] b);
`ifdef ALU_MULT_EARLY_EXIT_EN
        int msb = -1;
        for (int k = 0; k < 32; k++) if (b[k]) msb = k;
        return ((msb + 1) < 1 ? 1 : (msb + 1)) + 1;
`else
        return 33;
`endif
    endfunction

    // Monitor: pops one expectation on each rising OutValid; checks hold behaviour while stalled.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (out_valid === 1'b1 && !prev_ov) begin
            if (sb.size() == 0) begin
                check("unexpected_outvalid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", {31'd0, zero}, {31'd0, e.z});
                check("overflow", {31'd0, ovf}, {31'd0, e.o});
                check("illegal", {31'd0, ill}, {31'd0, e.i});
                check("latency", ncyc - e.stamp, e.lat);
            end
            held = result;
        end else if (out_valid === 1'b1 && prev_ov) begin
            check("held_result", result, held);
            check("inready_while_done", {31'd0, in_ready}, 32'd0);
        end
        prev_ov = (out_valid === 1'b1);
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push, input logic [31:0] er,
                         input logic ez, input logic eo, input logic ei, input int lat);
        int n = 0;
        @(negedge clk); #1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        ctrl     = c;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        in_valid = 1'b1;
        if (push) sb.push_back('{er, ez, eo, ei, lat, ncyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] er, input logic ez,
                      input logic eo, input logic ei);
        issue(c, a, b, sh, 1'b1, er, ez, eo, ei, 1);
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = 4'd0;
        op_a      = '0;
        op_b      = '0;
        shamt     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_inready", {31'd0, in_ready}, 32'd1);
        check("rst_outvalid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, zero, ovf, ill}, 32'd0);

        op(ALU_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        op(ALU_SUB,  32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        op(ALU_SUB,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        op(ALU_SUBU, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        op(ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0);
        op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        op(ALU_SRA,  32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        op(ALU_SRL,  32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        op(ALU_SLL,  32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        op(ALU_SRA,  32'h0, 32'h8000_0001, 5'd0, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
        op(ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
        op(ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
        op(ALU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0);
        op(ALU_NOR,  32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Accumulator starts at zero after reset: 0 + 12, then 12 + 30.
        issue(ALU_MULA, 32'd3, 32'd4, 5'd0, 1'b1, 32'd12, 1'b0, 1'b0, 1'b0, mula_lat(32'd4));
        drain();
        issue(ALU_MULA, 32'd5, 32'd6, 5'd0, 1'b1, 32'd42, 1'b0, 1'b0, 1'b0, mula_lat(32'd6));
        drain();

        // Stall the consumer; a new request and operand changes must not disturb the held result.
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1);
        ctrl     = ALU_OR;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Abort a long MULA in its tenth MUL cycle; no result may appear and Acc must clear.
        issue(ALU_MULA, 32'd7, 32'hFFFF_0000, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("abort_outvalid", {31'd0, out_valid}, 32'd0);
        check("abort_inready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        issue(ALU_MULA, 32'd2, 32'd3, 5'd0, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, mula_lat(32'd3));
        drain();

        op(4'b1111, 32'h1234_5678, 32'h1, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1);
        op(4'b1110, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
